timer_set_controller: RTL and testbench

//   Sequences the digital timer between counting and user time-setting. Debounces MODE/INC buttons,

---
 rtl/timer_set_controller.sv | 250 +++++++++++++++++++++++++
 tb/tb_timer_set_controller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_set_controller.sv
// timer_set_controller: debounces MODE/INC, sequences RUN -> SET_H -> SET_M -> SET_S -> COMMIT,
// holds the edited time with wrap, strobes the timer load and drives the per-field blink mask.

// Button conditioner: 2-flop synchronizer, stable-level debounce, rising-edge press pulse.
module timer_set_debounce #(
  parameter int DEBOUNCE_CYCLES = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button level into the clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

  // Accept a new level once it has differed for DEBOUNCE_CYCLES samples; pulse only on presses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_p1;
        cnt   <= '0;
        press <= sync_p1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

module timer_set_controller #(
  parameter int DEBOUNCE_CYCLES   = 50_000,
  parameter int BLINK_HALF_CYCLES = 12_500_000,
  parameter int TIMEOUT_CYCLES    = 500_000_000,
  parameter int HOURS_MAX         = 23
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_mode,
  input  logic       i_btn_inc,
  input  logic [6:0] i_hours,
  input  logic [5:0] i_minutes,
  input  logic [5:0] i_seconds,
  output logic       o_run,
  output logic       o_load,
  output logic       o_show_edit,
  output logic [6:0] o_edit_hours,
  output logic [5:0] o_edit_minutes,
  output logic [5:0] o_edit_seconds,
  output logic [2:0] o_blank
);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_H  = 3'd1,
    SET_M  = 3'd2,
    SET_S  = 3'd3,
    COMMIT = 3'd4
  } state_t;

  localparam int BLINK_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
  localparam int IDLE_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_CYCLES - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]         HOURS_LIM  = 7'(HOURS_MAX);
  localparam logic [5:0]         MINSEC_LIM = 6'd59;

  // Captured live values above their field maximum are treated as invalid and start from 0
  function automatic logic [6:0] clamp_hours(input logic [6:0] h);
    return (h > HOURS_LIM) ? 7'd0 : h;
  endfunction

  function automatic logic [5:0] clamp_minsec(input logic [5:0] v);
    return (v > MINSEC_LIM) ? 6'd0 : v;
  endfunction

  // Increment with wrap to zero at the field maximum
  function automatic logic [6:0] wrap_hours(input logic [6:0] h);
    return (h == HOURS_LIM) ? 7'd0 : h + 7'd1;
  endfunction

  function automatic logic [5:0] wrap_minsec(input logic [5:0] v);
    return (v == MINSEC_LIM) ? 6'd0 : v + 6'd1;
  endfunction

  // One-hot {hours,minutes,seconds} selection of the field being edited
  function automatic logic [2:0] field_mask(input state_t s);
    logic [2:0] m;
    case (s)
      SET_H:   m = 3'b100;
      SET_M:   m = 3'b010;
      SET_S:   m = 3'b001;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  logic mode_press;
  logic inc_raw;
  logic inc_press;

  state_t             state;
  state_t             state_nxt;
  logic [6:0]         hours_nxt;
  logic [5:0]         minutes_nxt;
  logic [5:0]         seconds_nxt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [IDLE_W-1:0]  idle_nxt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_nxt;
  logic               phase;
  logic               phase_nxt;
  logic               restart;

  timer_set_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk   (i_clk),
    .rst   (i_rst),
    .btn   (i_btn_mode),
    .press (mode_press)
  );

  timer_set_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk   (i_clk),
    .rst   (i_rst),
    .btn   (i_btn_inc),
    .press (inc_raw)
  );

  // MODE has priority: a coincident INC press is dropped
  assign inc_press = inc_raw & ~mode_press;

  // Next-state, edit-value, idle-timeout and blink-phase decisions
  always_comb begin
    state_nxt   = state;
    hours_nxt   = o_edit_hours;
    minutes_nxt = o_edit_minutes;
    seconds_nxt = o_edit_seconds;
    idle_nxt    = idle_cnt;
    blink_nxt   = blink_cnt;
    phase_nxt   = phase;
    restart     = 1'b0;

    case (state)
      RUN: begin
        if (mode_press) begin
          hours_nxt   = clamp_hours(i_hours);
          minutes_nxt = clamp_minsec(i_minutes);
          seconds_nxt = clamp_minsec(i_seconds);
          state_nxt   = SET_H;
          restart     = 1'b1;
        end
      end

      SET_H, SET_M, SET_S: begin
        if (mode_press) begin
          case (state)
            SET_H:   state_nxt = SET_M;
            SET_M:   state_nxt = SET_S;
            default: state_nxt = COMMIT;
          endcase
          restart = 1'b1;
        end else if (inc_press) begin
          case (state)
            SET_H:   hours_nxt   = wrap_hours(o_edit_hours);
            SET_M:   minutes_nxt = wrap_minsec(o_edit_minutes);
            default: seconds_nxt = wrap_minsec(o_edit_seconds);
          endcase
          restart = 1'b1;
        end else if (idle_cnt == IDLE_LAST) begin
          // Abandoned edit: back to counting, edit values kept, no load
          state_nxt = RUN;
        end else begin
          idle_nxt = idle_cnt + IDLE_W'(1);
          if (blink_cnt == BLINK_LAST) begin
            blink_nxt = '0;
            phase_nxt = ~phase;
          end else begin
            blink_nxt = blink_cnt + BLINK_W'(1);
          end
        end
      end

      COMMIT: state_nxt = RUN;

      default: state_nxt = RUN;
    endcase

    // Every entry into a SET state and every accepted press shows the field immediately
    if (restart) begin
      idle_nxt  = '0;
      blink_nxt = '0;
      phase_nxt = 1'b1;
    end
  end

  // State register with outputs registered from the next-state decode
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= RUN;
      idle_cnt       <= '0;
      blink_cnt      <= '0;
      phase          <= 1'b1;
      o_run          <= 1'b1;
      o_load         <= 1'b0;
      o_show_edit    <= 1'b0;
      o_edit_hours   <= '0;
      o_edit_minutes <= '0;
      o_edit_seconds <= '0;
      o_blank        <= 3'b000;
    end else begin
      state          <= state_nxt;
      idle_cnt       <= idle_nxt;
      blink_cnt      <= blink_nxt;
      phase          <= phase_nxt;
      o_run          <= (state_nxt == RUN);
      o_load         <= (state_nxt == COMMIT);
      o_show_edit    <= (state_nxt != RUN);
      o_edit_hours   <= hours_nxt;
      o_edit_minutes <= minutes_nxt;
      o_edit_seconds <= seconds_nxt;
      o_blank        <= field_mask(state_nxt) & {3{~phase_nxt}};
    end
  end

endmodule

// File: tb/tb_timer_set_controller.sv
// Bench for timer_set_controller: directed scenarios plus randomized button traffic,
// checked every cycle against a behavioural model of the setting sequence.
`timescale 1ns/1ps
module tb_timer_set_controller;

  localparam int DB = 4;
  localparam int BL = 8;
  localparam int TO = 200;
  localparam int HM = 23;

  localparam int S_RUN = 0;
  localparam int S_H   = 1;
  localparam int S_M   = 2;
  localparam int S_S   = 3;
  localparam int S_C   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [6:0] hours = '0;
  logic [5:0] minutes = '0;
  logic [5:0] seconds = '0;
  logic       run;
  logic       load;
  logic       show_edit;
  logic [6:0] edit_hours;
  logic [5:0] edit_minutes;
  logic [5:0] edit_seconds;
  logic [2:0] blank;

  int n_vec = 0;
  int n_bad = 0;
  int n_load = 0;

  // Reference model state
  int       ms;
  int       mh, mm, mss;
  int       idle, age;
  bit       pm, pi;
  bit       lvl_m, lvl_i;
  bit [7:0] hist_m, hist_i;

  timer_set_controller #(
    .DEBOUNCE_CYCLES   (DB),
    .BLINK_HALF_CYCLES (BL),
    .TIMEOUT_CYCLES    (TO),
    .HOURS_MAX         (HM)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_btn_mode     (btn_mode),
    .i_btn_inc      (btn_inc),
    .i_hours        (hours),
    .i_minutes      (minutes),
    .i_seconds      (seconds),
    .o_run          (run),
    .o_load         (load),
    .o_show_edit    (show_edit),
    .o_edit_hours   (edit_hours),
    .o_edit_minutes (edit_minutes),
    .o_edit_seconds (edit_seconds),
    .o_blank        (blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ms = S_RUN; mh = 0; mm = 0; mss = 0; idle = 0; age = 0;
    pm = 1'b0; pi = 1'b0; lvl_m = 1'b0; lvl_i = 1'b0; hist_m = '0; hist_i = '0;
  endtask

  // A button level is accepted when the last DB synchronized samples (raw input delayed
  // by two clocks) all disagree with the current level; only a new level of 1 is a press.
  task automatic db_step(input bit raw, inout bit [7:0] hist, inout bit lvl, output bit pulse);
    bit flip;
    hist = {hist[6:0], raw};
    flip = 1'b1;
    for (int j = 0; j < DB; j++) if (hist[2+j] == lvl) flip = 1'b0;
    pulse = 1'b0;
    if (flip) begin
      lvl   = ~lvl;
      pulse = lvl;
    end
  endtask

  // One clock edge of the behavioural model; presses act one edge after they are detected
  task automatic model_edge();
    bit m, i, nm, ni;
    if (rst) begin
      model_reset();
      return;
    end
    m = pm;
    i = pi && !pm;
    case (ms)
      S_RUN: if (m) begin
        mh  = (hours > HM) ? 0 : int'(hours);
        mm  = (minutes > 59) ? 0 : int'(minutes);
        mss = (seconds > 59) ? 0 : int'(seconds);
        ms = S_H; idle = 0; age = 0;
      end
      S_H, S_M, S_S: begin
        if (m) begin
          ms = ms + 1; idle = 0; age = 0;
        end else if (i) begin
          if (ms == S_H)      mh  = (mh + 1) % (HM + 1);
          else if (ms == S_M) mm  = (mm + 1) % 60;
          else                mss = (mss + 1) % 60;
          idle = 0; age = 0;
        end else if (idle == TO - 1) begin
          ms = S_RUN;
        end else begin
          idle++; age++;
        end
      end
      default: ms = S_RUN;
    endcase
    db_step(btn_mode, hist_m, lvl_m, nm);
    db_step(btn_inc, hist_i, lvl_i, ni);
    pm = nm;
    pi = ni;
  endtask

  task automatic compare_all();
    int eb;
    logic [18:0] ee;
    eb = 0;
    if ((ms == S_H || ms == S_M || ms == S_S) && ((age / BL) % 2) == 1)
      eb = (ms == S_H) ? 4 : (ms == S_M) ? 2 : 1;
    ee = {mh[6:0], mm[5:0], mss[5:0]};
    check("run", run, ms == S_RUN);
    check("load", load, ms == S_C);
    check("show_edit", show_edit, ms != S_RUN);
    check("edit", {edit_hours, edit_minutes, edit_seconds}, ee);
    check("blank", blank, eb);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (load === 1'b1) n_load++;
  endtask

  task automatic press(input bit m, input bit i, input int hold, input int gap);
    btn_mode = m;
    btn_inc  = i;
    repeat (hold) tick();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int saved_load;
    bit m, i;
    int sel, hold, gap;

    model_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_run", run, 1);
    check("rst_load", load, 0);
    check("rst_show", show_edit, 0);
    check("rst_edit", {edit_hours, edit_minutes, edit_seconds}, 0);
    check("rst_blank", blank, 0);
    repeat (4) tick();

    // Capture latency and blink cadence
    hours = 7'd10; minutes = 6'd20; seconds = 6'd30;
    btn_mode = 1'b1;
    repeat (6) tick();
    check("lat_still_run", run, 1);
    tick();
    check("lat_run_fell", run, 0);
    check("lat_edit", {edit_hours, edit_minutes, edit_seconds}, {7'd10, 6'd20, 6'd30});
    repeat (7) tick();
    check("blink_visible_end", blank, 3'b000);
    tick();
    check("blink_blank_start", blank, 3'b100);
    repeat (7) tick();
    check("blink_blank_end", blank, 3'b100);
    tick();
    check("blink_visible_again", blank, 3'b000);
    btn_mode = 1'b0;
    repeat (8) tick();

    // Glitch on MODE: still editing hours, so INC bumps hours
    press(1'b1, 1'b0, 3, 10);
    check("glitch_hours", edit_hours, 10);
    press(1'b0, 1'b1, 6, 8);
    check("glitch_then_inc", edit_hours, 11);

    // Hours wrap
    repeat (11) press(1'b0, 1'b1, 6, 8);
    check("hours_22", edit_hours, 22);
    press(1'b0, 1'b1, 6, 8);
    check("hours_23", edit_hours, 23);
    press(1'b0, 1'b1, 6, 8);
    check("hours_wrap", edit_hours, 0);

    // SET_M, then simultaneous MODE+INC -> SET_S with minutes untouched
    press(1'b1, 1'b0, 6, 8);
    press(1'b1, 1'b1, 6, 8);
    check("both_minutes", edit_minutes, 20);
    tick();
    check("both_in_set_s", blank, 3'b001);

    // Idle timeout back to RUN with no load
    repeat (TO + 10) tick();
    check("timeout_run", run, 1);
    check("timeout_noload", n_load, 0);
    check("timeout_edit", {edit_hours, edit_minutes, edit_seconds}, {7'd0, 6'd20, 6'd30});

    // Out-of-range capture, minutes wrap, commit
    hours = 7'd30; minutes = 6'd59; seconds = 6'd45;
    press(1'b1, 1'b0, 6, 8);
    check("cap_hours_clamped", edit_hours, 0);
    check("cap_minutes", edit_minutes, 59);
    press(1'b1, 1'b0, 6, 8);
    press(1'b0, 1'b1, 6, 8);
    check("minutes_wrap", edit_minutes, 0);
    press(1'b1, 1'b0, 6, 8);
    btn_mode = 1'b1;
    k = 0;
    while (load !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("commit_seen", load, 1);
    check("commit_run", run, 0);
    check("commit_blank", blank, 0);
    check("commit_edit", {edit_hours, edit_minutes, edit_seconds}, {7'd0, 6'd0, 6'd45});
    tick();
    check("commit_next_run", run, 1);
    check("commit_next_load", load, 0);
    check("commit_count", n_load, 1);
    btn_mode = 1'b0;
    repeat (8) tick();

    // Asynchronous reset in the middle of SET_M
    hours = 7'd5; minutes = 6'd6; seconds = 6'd7;
    press(1'b1, 1'b0, 6, 8);
    press(1'b1, 1'b0, 6, 8);
    check("pre_rst_show", show_edit, 1);
    saved_load = n_load;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_run", run, 1);
    check("arst_load", load, 0);
    check("arst_show", show_edit, 0);
    check("arst_edit", {edit_hours, edit_minutes, edit_seconds}, 0);
    check("arst_blank", blank, 0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("post_rst_run", run, 1);
    check("post_rst_noload", n_load, saved_load);

    // Randomized button traffic
    for (int r = 0; r < 80; r++) begin
      hours   = 7'($urandom_range(0, 127));
      minutes = 6'($urandom_range(0, 63));
      seconds = 6'($urandom_range(0, 63));
      sel  = int'($urandom_range(0, 9));
      hold = (sel == 9) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 8));
      gap  = int'($urandom_range(5, 12));
      m = (sel <= 3) || (sel == 8) || (sel == 9 && $urandom_range(0, 1) == 0);
      i = (sel >= 4 && sel <= 8) || (sel == 9 && !m);
      press(m, i, hold, gap);
      if ($urandom_range(0, 19) == 0) repeat (TO) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
